// File: rtl/regfile_mp.sv
// Multi-ported register file: 2 combinational read ports, 2 write ports,
// pending-write scoreboard, and a post-reset clear sequence that zeroes every register.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   wa0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            pend1,
    output logic            pend2,
    output logic            busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            busy_q;
    logic [NREG-1:0] sb_q, sb_d;
    logic [XLEN-1:0] mem_q [NREG];

    logic run, wacc0, wacc1, sbacc;

    assign run   = (state_q == RUN);
    assign wacc0 = run && we0 && (wa0 != '0);
    assign wacc1 = run && we1 && (wa1 != '0);
    assign sbacc = run && sb_set && (sb_addr != '0);
    assign busy  = busy_q;

    // Set is applied after the write-clears so a newer producer keeps the bit.
    always_comb begin
        sb_d = sb_q;
        if (wacc0) sb_d[wa0] = 1'b0;
        if (wacc1) sb_d[wa1] = 1'b0;
        if (sbacc) sb_d[sb_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= AW'(1);
            busy_q    <= 1'b1;
            sb_q      <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                    if (clr_cnt_q == AW'(NREG - 1)) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: sb_q <= sb_d;
            endcase
        end
    end

    // Storage is not reset; the clear sequence zeroes it. Entry 0 is never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                if (wacc0) mem_q[wa0] <= wd0;
                if (wacc1) mem_q[wa1] <= wd1;
            end
        end
    end

    function automatic logic [XLEN-1:0] rd_fn(input logic [AW-1:0] ra);
        logic [XLEN-1:0] r;
        r = '0;
        if (run && ra != '0) begin
            if (BYPASS != 0 && wacc1 && wa1 == ra)      r = wd1;
            else if (BYPASS != 0 && wacc0 && wa0 == ra) r = wd0;
            else                                        r = mem_q[ra];
        end
        return r;
    endfunction

    // A same-cycle write retires the pending producer unless a new one claims the slot.
    function automatic logic pend_fn(input logic [AW-1:0] ra);
        logic p;
        p = 1'b0;
        if (run && ra != '0) begin
            p = sb_q[ra];
            if (BYPASS != 0 && ((wacc0 && wa0 == ra) || (wacc1 && wa1 == ra))
                && !(sbacc && sb_addr == ra))
                p = 1'b0;
        end
        return p;
    endfunction

    always_comb begin
        rd1   = rd_fn(ra1);
        rd2   = rd_fn(ra2);
        pend1 = pend_fn(ra1);
        pend2 = pend_fn(ra2);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing
// instance driven by the same stimulus.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   ra1, ra2, wa0, wa1, sb_addr;
    logic            we0, we1, sb_set;
    logic [XLEN-1:0] wd0, wd1;

    logic [XLEN-1:0] rd1, rd2, rd1_nb, rd2_nb;
    logic            pend1, pend2, busy, pend1_nb, pend2_nb, busy_nb;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1), .pend2(pend2), .busy(busy)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1_nb), .pend2(pend2_nb), .busy(busy_nb)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; sb_set = 0;
        wa0 = '0; wa1 = '0; sb_addr = '0; wd0 = '0; wd1 = '0;
    endtask

    // Counts edges until busy drops, bounded so a stuck DUT still terminates.
    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1; ra1 = 5; ra2 = 3;
        cyc(); cyc();
        #2;
        n_chk++; if (busy !== 1'b1 || busy_nb !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b/%b exp 1", busy, busy_nb); end
        n_chk++; if (rd1 !== '0 || rd2 !== '0) begin n_fail++; $display("FAIL reset_rd: got %h/%h exp 0", rd1, rd2); end
        n_chk++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b/%b exp 0", pend1, pend2); end
        cyc();
        rst = 0;
        wait_clear(n);
        n_chk++; if (n !== 31) begin n_fail++; $display("FAIL first_clear_len: got %0d exp 31", n); end
        n_chk++; if (busy_nb !== 1'b0) begin n_fail++; $display("FAIL first_clear_nb_busy: got %b exp 0", busy_nb); end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1; wa0 = 5; wd0 = 32'h1234; ra1 = 5;
        #2;
        n_chk++; if (rd1 !== 32'h1234) begin n_fail++; $display("FAIL bypass_fwd: got %h exp 1234", rd1); end
        n_chk++; if (rd1_nb !== 32'h0) begin n_fail++; $display("FAIL nobypass_same: got %h exp 0", rd1_nb); end
        cyc();
        we0 = 0;
        #2;
        n_chk++; if (rd1 !== 32'h1234 || rd1_nb !== 32'h1234) begin n_fail++; $display("FAIL bypass_next: got %h/%h exp 1234", rd1, rd1_nb); end
        cyc();
    endtask

    task automatic test_same_addr();
        idle();
        we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'hAAAA; wd1 = 32'h5555; ra1 = 7;
        #2;
        n_chk++; if (rd1 !== 32'h5555) begin n_fail++; $display("FAIL same_addr_fwd: got %h exp 5555", rd1); end
        cyc();
        idle();
        #2;
        n_chk++; if (rd1 !== 32'h5555 || rd1_nb !== 32'h5555) begin n_fail++; $display("FAIL same_addr_store: got %h/%h exp 5555", rd1, rd1_nb); end
        cyc();
    endtask

    task automatic test_scoreboard();
        idle();
        ra1 = 3; ra2 = 3; sb_set = 1; sb_addr = 3;
        #2;
        n_chk++; if (pend1 !== 1'b0) begin n_fail++; $display("FAIL sb_before_edge: got %b exp 0", pend1); end
        cyc();
        sb_set = 0;
        #2;
        n_chk++; if (pend1 !== 1'b1 || pend1_nb !== 1'b1 || pend2 !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b/%b/%b exp 1", pend1, pend1_nb, pend2); end
        we0 = 1; wa0 = 3; wd0 = 32'h33;
        #2;
        n_chk++; if (pend1 !== 1'b0 || pend1_nb !== 1'b1) begin n_fail++; $display("FAIL sb_write_same_cycle: got %b/%b exp 0/1", pend1, pend1_nb); end
        cyc();
        idle();
        #2;
        n_chk++; if (pend1 !== 1'b0 || pend1_nb !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b/%b exp 0", pend1, pend1_nb); end
        sb_set = 1; sb_addr = 3; we1 = 1; wa1 = 3; wd1 = 32'h44;
        cyc();
        idle();
        #2;
        n_chk++; if (pend1 !== 1'b1 || pend1_nb !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b/%b exp 1", pend1, pend1_nb); end
        n_chk++; if (rd1 !== 32'h44) begin n_fail++; $display("FAIL sb_set_wins_data: got %h exp 44", rd1); end
        we0 = 1; wa0 = 3; wd0 = 32'h44;
        cyc();
        idle();
    endtask

    task automatic test_zero();
        idle();
        we0 = 1; wa0 = 0; wd0 = 32'hDEAD; sb_set = 1; sb_addr = 0; ra1 = 0; ra2 = 0;
        #2;
        n_chk++; if (rd1 !== '0 || pend1 !== 1'b0) begin n_fail++; $display("FAIL zero_same_cycle: got %h/%b exp 0/0", rd1, pend1); end
        cyc();
        idle();
        #2;
        n_chk++; if (rd1 !== '0 || rd1_nb !== '0 || pend1 !== 1'b0 || pend2_nb !== 1'b0) begin n_fail++; $display("FAIL zero_after: got %h/%h/%b exp 0", rd1, rd1_nb, pend1); end
        cyc();
    endtask

    task automatic test_back_to_back();
        idle();
        we0 = 1; wa0 = 10; wd0 = 32'hA0; we1 = 1; wa1 = 11; wd1 = 32'hB1;
        sb_set = 1; sb_addr = 12;
        cyc();
        idle();
        we0 = 1; wa0 = 12; wd0 = 32'hC2; we1 = 1; wa1 = 10; wd1 = 32'hD3;
        ra1 = 10; ra2 = 12;
        #2;
        n_chk++; if (rd1 !== 32'hD3 || rd2 !== 32'hC2) begin n_fail++; $display("FAIL b2b_fwd: got %h/%h exp d3/c2", rd1, rd2); end
        n_chk++; if (rd1_nb !== 32'hA0) begin n_fail++; $display("FAIL b2b_nb_old: got %h exp a0", rd1_nb); end
        n_chk++; if (pend2 !== 1'b0 || pend2_nb !== 1'b1) begin n_fail++; $display("FAIL b2b_pend: got %b/%b exp 0/1", pend2, pend2_nb); end
        cyc();
        idle();
        #2;
        n_chk++; if (rd1_nb !== 32'hD3 || rd2_nb !== 32'hC2 || pend2_nb !== 1'b0) begin n_fail++; $display("FAIL b2b_stored: got %h/%h/%b exp d3/c2/0", rd1_nb, rd2_nb, pend2_nb); end
        ra1 = 11;
        #1;
        n_chk++; if (rd1 !== 32'hB1) begin n_fail++; $display("FAIL b2b_port1: got %h exp b1", rd1); end
        cyc();
    endtask

    task automatic test_clear_len();
        int n;
        int bad;
        idle();
        for (int a = 1; a < NREG; a++) begin
            we0 = 1; wa0 = AW'(a); wd0 = 32'hFFFF_FFFF;
            cyc();
        end
        idle();
        ra1 = 9;
        #2;
        n_chk++; if (rd1_nb !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL preload: got %h exp ffffffff", rd1_nb); end
        rst = 1;
        cyc();
        rst = 0;
        wait_clear(n);
        n_chk++; if (n !== 31) begin n_fail++; $display("FAIL clear_len: got %0d exp 31", n); end
        bad = 0;
        for (int a = 0; a < NREG; a++) begin
            ra1 = AW'(a); ra2 = AW'(NREG - 1 - a);
            #1;
            if (rd1 !== '0 || rd2 !== '0 || rd1_nb !== '0) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL clear_zero: got %0d nonzero reads exp 0", bad); end
        cyc();
    endtask

    task automatic test_reset_midclear();
        int n;
        idle();
        rst = 1;
        cyc();
        rst = 0;
        we0 = 1; wa0 = 2; wd0 = 32'hBEEF; ra1 = 2;
        repeat (9) cyc();
        #2;
        n_chk++; if (busy !== 1'b1 || rd1 !== '0) begin n_fail++; $display("FAIL midclear_state: got %b/%h exp 1/0", busy, rd1); end
        rst = 1;
        #1;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclear_rst_busy: got %b exp 1", busy); end
        cyc();
        rst = 0;
        wait_clear(n);
        we0 = 0;
        n_chk++; if (n !== 31) begin n_fail++; $display("FAIL midclear_len: got %0d exp 31", n); end
        #2;
        n_chk++; if (rd1 !== '0 || rd1_nb !== '0) begin n_fail++; $display("FAIL clear_write_ignored: got %h/%h exp 0", rd1, rd1_nb); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ra1 = '0; ra2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_same_addr();
        test_scoreboard();
        test_zero();
        test_back_to_back();
        test_clear_len();
        test_reset_midclear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
